dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 1024, number of bytes in the shared data memory; byte addresses at or above it are out of range.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 req0, req1  input  1 each  access request from port 0 (CPU load/store) and port 1 (DMA/debug).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  32 each  byte address.
REQ-007 wd0, wd1  input  32 each  write data, little-endian; only bits [7:0] used for byte ops.
REQ-008 byte0, byte1  input  1 each  1 = byte access, 0 = 4-byte word access.
REQ-009 ack0, ack1  output  1 each  single-cycle completion pulse for the port.
REQ-010 err  output  1  high with ack when the completed access was out of range.
REQ-011 rdata  output  32  read result, valid while ack0 or ack1 is high.
REQ-012 mem_we  output  1; mem_a  output  32; mem_wd  output  32; mem_byte  output  1  command to the data memory.
REQ-013 mem_rd  input  32  combinational read data from the data memory.

Function
REQ-014 FSM states: IDLE, ACCESS, DONE; reset state IDLE.
REQ-015 IDLE: if no req, stay IDLE; if any req, capture the winner's we/addr/wd/byte and port id into command registers and go to ACCESS.
REQ-016 Arbitration: only one req -> that port wins; both -> port other than last_grant wins (round-robin); last_grant updates to the winner on capture.
REQ-017 ACCESS (exactly one cycle): mem_a, mem_wd, mem_byte driven from command registers; mem_we = captured we AND in-range; mem_rd sampled into rdata register at the end of the cycle; next state DONE.
REQ-018 Outside ACCESS: mem_we = 0; mem_a, mem_wd, mem_byte hold the last command values.
REQ-019 Range check: word in range iff addr + 3 < ADDR_LIMIT (33-bit add, no wrap); byte in range iff addr < ADDR_LIMIT.
REQ-020 Out-of-range access: no memory write; rdata = 0; err = 1 with ack.
REQ-021 Read rdata: word -> mem_rd unchanged; byte -> {24'b0, mem_rd[7:0]}; write -> rdata = 0.
REQ-022 DONE (one cycle): ackN = 1 for the captured port only, err as computed; next state IDLE; req inputs not sampled in ACCESS or DONE.
REQ-023 Latency: req seen in IDLE at edge k -> memory access cycle k+1 -> ack in cycle k+2; throughput one access per 3 cycles.
REQ-024 Requester holds req and its command stable until ack; it may drop req or present a new command in the cycle after ack.
REQ-025 req dropped during ACCESS/DONE: captured command still completes and ack still pulses.
REQ-026 ack0 and ack1 never high in the same cycle; at most one ack per capture.

Reset
REQ-027 rst low: immediately state = IDLE, last_grant = 1 (port 0 wins first tie), ack0 = ack1 = err = 0, mem_we = 0, rdata = 0, mem_a = mem_wd = 0, mem_byte = 0.
REQ-028 Reset during ACCESS or DONE aborts the access with no ack; a write aborted before the ACCESS-cycle edge is not performed.
REQ-029 First capture is at the first rising edge with rst high and any req high.

Verification
REQ-030 Word write then read, port 0: write addr 0x10, wd 0xDEADBEEF -> mem_we high 1 cycle, ack0 2 cycles after capture; read 0x10 -> rdata 0xDEADBEEF with ack0, err 0.
REQ-031 Byte read, port 1: memory word at 0x20 = 0x11223344, byte1 = 1 -> rdata 0x00000044, ack1 only.
REQ-032 Simultaneous req0/req1 held from reset: grants alternate 0,1,0,1; each ack 3 cycles apart; no double ack.
REQ-033 Range: word write addr 1021 (ADDR_LIMIT 1024) -> mem_we stays 0, err = 1 with ack; word at 1020 and byte at 1023 -> err 0; addr 0xFFFFFFFE word -> err 1 (no wrap).
REQ-034 Reset pulse in ACCESS of a write -> no ack, FSM IDLE, subsequent read shows old data; after release, tied requests served port 0 first.
REQ-035 req0 dropped in the ACCESS cycle -> ack0 still pulses once; next IDLE with no req stays IDLE, mem_we 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
//
// Port 0 (CPU load/store) and port 1 (DMA/debug) compete for the memory. A request seen
// in IDLE is captured into command registers, the memory is accessed for exactly one
// cycle (ACCESS), and the winning port receives a one-cycle ack in DONE. One access
// completes every three cycles. Ties are resolved round-robin against the last grant.
//
// Ports:
//   clk                    single clock, rising-edge
//   rst                    asynchronous active-low reset
//   req0/req1              access request per port
//   we0/we1                1 = write, 0 = read
//   addr0/addr1 [31:0]     byte address
//   wd0/wd1     [31:0]     write data (little-endian, [7:0] for byte ops)
//   byte0/byte1            1 = byte access, 0 = word access
//   ack0/ack1              completion pulse for the port
//   err                    with ack: completed access was out of range
//   rdata       [31:0]     read result, valid with ack
//   mem_we/mem_a/mem_wd/mem_byte   command to the data memory
//   mem_rd      [31:0]     combinational read data from the data memory
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  input  logic        byte0,
  input  logic        byte1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_byte,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic        lastGrant;
  logic        grant;
  logic        anyReq;

  // Command registers: loaded on capture, held until the next capture so the memory
  // command lines stay stable outside ACCESS.
  logic        cmdPort;
  logic        cmdWe;
  logic        cmdByte;
  logic [31:0] cmdAddr;
  logic [31:0] cmdWd;

  logic [31:0] rdataQ;
  logic [31:0] rdataNext;
  logic [32:0] lastByteAddr;
  logic        inRange;

  // Winner selection: a lone requester wins; on a tie the port that did not win last.
  always_comb begin
    anyReq = req0 | req1;
    if (req0 && req1) begin
      grant = ~lastGrant;
    end else begin
      grant = req1;
    end
  end

  // Address of the last byte touched, in 33 bits so a word near 2^32 cannot wrap back
  // into range.
  always_comb begin
    lastByteAddr = {1'b0, cmdAddr} + (cmdByte ? 33'd0 : 33'd3);
    inRange      = lastByteAddr < 33'(ADDR_LIMIT);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = ACCESS;
        end
      end
      ACCESS:  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Writes and out-of-range accesses return zero; byte reads take the addressed byte,
  // which the memory presents on mem_rd[7:0].
  always_comb begin
    if (!inRange || cmdWe) begin
      rdataNext = 32'h0;
    end else if (cmdByte) begin
      rdataNext = {24'h0, mem_rd[7:0]};
    end else begin
      rdataNext = mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      cmdPort   <= 1'b0;
      cmdWe     <= 1'b0;
      cmdByte   <= 1'b0;
      cmdAddr   <= 32'h0;
      cmdWd     <= 32'h0;
      rdataQ    <= 32'h0;
    end else begin
      state <= stateNext;
      if (state == IDLE && anyReq) begin
        lastGrant <= grant;
        cmdPort   <= grant;
        cmdWe     <= grant ? we1 : we0;
        cmdByte   <= grant ? byte1 : byte0;
        cmdAddr   <= grant ? addr1 : addr0;
        cmdWd     <= grant ? wd1 : wd0;
      end
      if (state == ACCESS) begin
        rdataQ <= rdataNext;
      end
    end
  end

  always_comb begin
    ack0     = (state == DONE) && !cmdPort;
    ack1     = (state == DONE) && cmdPort;
    err      = (state == DONE) && !inRange;
    rdata    = rdataQ;
    mem_we   = (state == ACCESS) && cmdWe && inRange;
    mem_a    = cmdAddr;
    mem_wd   = cmdWd;
    mem_byte = cmdByte;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle corner
// sequences (round-robin ties, reset abort, request drop) and random transactions
// checked against a transaction-level model with a shadow byte memory.
module tb_dmem_arbiter;

  localparam int unsigned LIMIT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0, req1, we0, we1, byte0, byte1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic        ack0, ack1, err, mem_we, mem_byte;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem    [LIMIT];
  logic [7:0] shadow [LIMIT];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wd0      (wd0),
    .wd1      (wd1),
    .byte0    (byte0),
    .byte1    (byte1),
    .ack0     (ack0),
    .ack1     (ack1),
    .err      (err),
    .rdata    (rdata),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_byte (mem_byte),
    .mem_rd   (mem_rd)
  );

  // Data memory: little-endian bytes; bytes past the end read as 0xA5 so that a
  // missing zeroing of out-of-range reads is visible.
  always_comb begin
    logic [63:0] ix;
    mem_rd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ix = {32'h0, mem_a} + 64'(k);
      if (ix < 64'(LIMIT)) mem_rd[8*k +: 8] = mem[int'(ix)];
      else mem_rd[8*k +: 8] = 8'hA5;
    end
  end

  initial begin
    logic [63:0] ix;
    for (int i = 0; i < int'(LIMIT); i++) mem[i] = 8'((i * 37 + 11) & 255);
    forever begin
      @(posedge clk);
      if (mem_we) begin
        for (int k = 0; k < (mem_byte ? 1 : 4); k++) begin
          ix = {32'h0, mem_a} + 64'(k);
          if (ix < 64'(LIMIT)) mem[int'(ix)] = mem_wd[8*k +: 8];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic setPort(input int p, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit b);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wd0 = d; byte0 = b;
    end else begin
      req1 = r; we1 = w; addr1 = a; wd1 = d; byte1 = b;
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_ack0"}, 32'(ack0), 32'h0);
    check({tag, "_ack1"}, 32'(ack1), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_mem_a"}, mem_a, 32'h0);
    check({tag, "_mem_wd"}, mem_wd, 32'h0);
    check({tag, "_mem_byte"}, 32'(mem_byte), 32'h0);
  endtask

  function automatic logic [31:0] shadowWord(input int a);
    return {shadow[a + 3], shadow[a + 2], shadow[a + 1], shadow[a]};
  endfunction

  // Transaction-level model: decides range, error and read result, and applies writes.
  task automatic modelTxn(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit b, output bit eErr, output logic [31:0] eRd);
    longint last;
    last = longint'({32'h0, a}) + (b ? 0 : 3);
    eRd  = 32'h0;
    eErr = !(last < longint'(LIMIT));
    if (!eErr) begin
      if (w) begin
        shadow[int'(a)] = d[7:0];
        if (!b) begin
          shadow[int'(a) + 1] = d[15:8];
          shadow[int'(a) + 2] = d[23:16];
          shadow[int'(a) + 3] = d[31:24];
        end
      end else begin
        eRd = b ? {24'h0, shadow[int'(a)]} : shadowWord(int'(a));
      end
    end
  endtask

  // One single-port transaction from IDLE: ack expected two cycles after the drive edge.
  task automatic runTxn(input string tag, input int p, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit b, input bit eErr,
                        input logic [31:0] eRd);
    int lat, weCnt;
    bit got, a0, a1, er;
    logic [31:0] rd;
    lat = 0; weCnt = 0; got = 0; a0 = 0; a1 = 0; er = 0; rd = 32'h0;
    @(negedge clk);
    setPort(p, 1'b1, w, a, d, b);
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_we) weCnt++;
      if (c == 1) begin
        check({tag, "_mem_a"}, mem_a, a);
        check({tag, "_mem_byte"}, 32'(mem_byte), 32'(b));
        if (w) check({tag, "_mem_wd"}, mem_wd, d);
      end
      if (ack0 || ack1) begin
        got = 1; lat = c; a0 = ack0; a1 = ack1; er = err; rd = rdata;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_ack0"}, 32'(a0), 32'(p == 0));
    check({tag, "_ack1"}, 32'(a1), 32'(p == 1));
    check({tag, "_err"}, 32'(er), 32'(eErr));
    check({tag, "_rdata"}, rd, eRd);
    check({tag, "_mem_we_cycles"}, 32'(weCnt), 32'(w && !eErr));
    setPort(p, 1'b0, w, a, d, b);
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          byt;
    bit          expErr;
    logic [31:0] expRd;
  } vec_t;

  initial begin
    vec_t vecs[$];
    bit          mErr;
    logic [31:0] mRd;
    int          n, lat, ackPort;
    bit          got;
    logic [31:0] rd;
    int          expPort [4];
    int          expCyc [4];
    logic [31:0] expRdv [4];
    int          gotPort [4];
    int          gotCyc [4];
    logic [31:0] gotRd [4];

    setPort(0, 0, 0, 32'h0, 32'h0, 0);
    setPort(1, 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < int'(LIMIT); i++) shadow[i] = 8'((i * 37 + 11) & 255);

    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b1;
    @(negedge clk);
    checkReset("idle_after_reset");

    // Directed vectors, expected values worked out by hand.
    vecs.push_back('{0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0});
    vecs.push_back('{0, 0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF});
    vecs.push_back('{1, 1, 32'h20, 32'h11223344, 0, 0, 32'h0});
    vecs.push_back('{1, 0, 32'h20, 32'h0, 1, 0, 32'h00000044});
    vecs.push_back('{0, 1, 32'd1021, 32'h12345678, 0, 1, 32'h0});
    vecs.push_back('{0, 1, 32'd1020, 32'hCAFEF00D, 0, 0, 32'h0});
    vecs.push_back('{1, 0, 32'd1020, 32'h0, 0, 0, 32'hCAFEF00D});
    vecs.push_back('{0, 1, 32'd1023, 32'hABCDEF99, 1, 0, 32'h0});
    vecs.push_back('{0, 0, 32'd1023, 32'h0, 1, 0, 32'h00000099});
    vecs.push_back('{1, 0, 32'hFFFFFFFE, 32'h0, 0, 1, 32'h0});
    vecs.push_back('{1, 0, 32'd1021, 32'h0, 0, 1, 32'h0});
    vecs.push_back('{0, 0, 32'd1020, 32'h0, 0, 0, 32'h99FEF00D});
    vecs.push_back('{1, 0, 32'h13, 32'h0, 1, 0, 32'h000000DE});
    vecs.push_back('{0, 1, 32'hFFFFFFFF, 32'h55, 1, 1, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      modelTxn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].byt, mErr, mRd);
      runTxn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wd,
             vecs[i].byt, vecs[i].expErr, vecs[i].expRd);
    end

    // Both ports requesting from reset: grants alternate starting with port 0.
    @(negedge clk);
    rst = 1'b0;
    setPort(0, 1, 0, 32'h10, 32'h0, 0);
    setPort(1, 1, 0, 32'h20, 32'h0, 1);
    #1;
    checkReset("tie_in_reset");
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("tie_no_double_ack", 32'(ack0 & ack1), 32'h0);
      if ((ack0 || ack1) && n < 4) begin
        gotPort[n] = ack1 ? 1 : 0;
        gotCyc[n]  = c;
        gotRd[n]   = rdata;
        n++;
      end else if (ack0 || ack1) begin
        n++;
      end
    end
    setPort(0, 0, 0, 32'h10, 32'h0, 0);
    setPort(1, 0, 0, 32'h20, 32'h0, 1);
    expPort = '{0, 1, 0, 1};
    expCyc  = '{2, 5, 8, 11};
    expRdv  = '{shadowWord(16), {24'h0, shadow[32]}, shadowWord(16), {24'h0, shadow[32]}};
    check("tie_ack_count", 32'(n), 32'd4);
    for (int i = 0; i < 4 && i < n; i++) begin
      check($sformatf("tie%0d_port", i), 32'(gotPort[i]), 32'(expPort[i]));
      check($sformatf("tie%0d_cycle", i), 32'(gotCyc[i]), 32'(expCyc[i]));
      check($sformatf("tie%0d_rdata", i), gotRd[i], expRdv[i]);
    end

    // Reset in the ACCESS cycle of a write: the write must not land.
    modelTxn(1, 32'h40, 32'h01020304, 0, mErr, mRd);
    runTxn("abort_setup", 0, 1, 32'h40, 32'h01020304, 0, 0, 32'h0);
    @(negedge clk);
    setPort(0, 1, 1, 32'h40, 32'hFFFFFFFF, 0);
    @(negedge clk);
    check("abort_mem_we_before", 32'(mem_we), 32'h1);
    rst = 1'b0;
    #1;
    checkReset("abort");
    setPort(0, 0, 1, 32'h40, 32'hFFFFFFFF, 0);
    @(negedge clk);
    checkReset("abort_hold");
    setPort(0, 1, 0, 32'h40, 32'h0, 0);
    setPort(1, 1, 0, 32'h10, 32'h0, 0);
    rst = 1'b1;
    got = 0; lat = 0; ackPort = -1; rd = 32'h0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = 1; lat = c; ackPort = ack1 ? 1 : 0; rd = rdata;
      end
    end
    check("abort_first_latency", 32'(lat), 32'd2);
    check("abort_first_port", 32'(ackPort), 32'd0);
    check("abort_old_data", rd, 32'h01020304);
    setPort(0, 0, 0, 32'h40, 32'h0, 0);
    got = 0; lat = 0; ackPort = -1; rd = 32'h0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = 1; lat = c; ackPort = ack1 ? 1 : 0; rd = rdata;
      end
    end
    check("abort_second_latency", 32'(lat), 32'd3);
    check("abort_second_port", 32'(ackPort), 32'd1);
    check("abort_second_rdata", rd, shadowWord(16));
    setPort(1, 0, 0, 32'h10, 32'h0, 0);

    // Request dropped during ACCESS: the access still completes exactly once.
    @(negedge clk);
    setPort(0, 1, 0, 32'h10, 32'h0, 0);
    @(negedge clk);
    setPort(0, 0, 0, 32'h10, 32'h0, 0);
    n = 0; lat = 0; rd = 32'h0;
    got = 0;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (ack0) begin
        n++; lat = c; rd = rdata;
      end
      if (ack1 || mem_we) got = 1;
    end
    check("drop_ack0_count", 32'(n), 32'd1);
    check("drop_ack0_cycle", 32'(lat), 32'd2);
    check("drop_rdata", rd, shadowWord(16));
    check("drop_idle_quiet", 32'(got), 32'h0);

    // Random single-port transactions against the model.
    for (int i = 0; i < 60; i++) begin
      int p, r;
      bit w, b;
      logic [31:0] a, d;
      p = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      d = $urandom;
      r = int'($urandom_range(0, 7));
      if (r < 6) a = $urandom_range(0, LIMIT - 1);
      else if (r == 6) a = $urandom_range(LIMIT - 4, LIMIT + 4);
      else a = $urandom;
      modelTxn(w, a, d, b, mErr, mRd);
      runTxn($sformatf("rnd%0d", i), p, w, a, d, b, mErr, mRd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
